// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the M-extension execute unit:
// funct3/funct7 encodings and the multiply/divide FSM states.
package riscv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // All divide/remainder encodings have funct3[2] set.
    function automatic logic op_is_div(input logic [2:0] f);
        return f[2];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation: turns signed operands into magnitudes
// and applies the final sign to products, quotients and remainders.
module muldiv_signfix #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] val_i,
    input  logic            neg_i,
    output logic [XLEN-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + XLEN'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one result bit per cycle via
// shift-add multiply or restoring divide, valid/ready on both sides.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_e     state_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   b_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    // ---------------- acceptance-time decode ----------------
    logic            rs1_signed, rs2_signed;
    logic            rs1_neg, rs2_neg;
    logic [XLEN-1:0] rs1_mag, rs2_mag;
    logic            res_neg_d;
    logic            div_by_zero, div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        rs1_signed = funct3 inside {MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
        rs2_signed = funct3 inside {MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
    end

    assign rs1_neg = rs1_signed & rs1[XLEN-1];
    assign rs2_neg = rs2_signed & rs2[XLEN-1];

    muldiv_signfix #(.XLEN(XLEN)) u_rs1_mag (.val_i(rs1), .neg_i(rs1_neg), .val_o(rs1_mag));
    muldiv_signfix #(.XLEN(XLEN)) u_rs2_mag (.val_i(rs2), .neg_i(rs2_neg), .val_o(rs2_mag));

    always_comb begin
        res_neg_d = 1'b0;
        case (funct3)
            MULDIV_REM:  res_neg_d = rs1_neg;
            MULDIV_DIVU,
            MULDIV_REMU: res_neg_d = 1'b0;
            default:     res_neg_d = rs1_neg ^ rs2_neg;
        endcase
    end

    assign div_by_zero = op_is_div(funct3) && (rs2 == '0);
    assign div_ovf     = ((funct3 == MULDIV_DIV) || (funct3 == MULDIV_REM))
                         && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

    // funct3[1] separates REM/REMU from DIV/DIVU.
    always_comb begin
        if (div_by_zero) special_res = funct3[1] ? rs1 : '1;
        else             special_res = funct3[1] ? '0  : rs1;
    end

    // ---------------- iteration datapath ----------------
    logic [XLEN-1:0]   hi, lo;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_diff;
    logic [2*XLEN-1:0] mul_next, div_next, acc_d;

    assign hi = acc_q[2*XLEN-1:XLEN];
    assign lo = acc_q[XLEN-1:0];

    // Multiply: hi accumulates the multiplicand, lo shifts the multiplier out.
    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, lo[XLEN-1:1]};

    // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
    assign rem_shift = {hi, lo[XLEN-1]};
    assign rem_ge    = rem_shift >= {1'b0, b_q};
    assign rem_diff  = rem_shift[XLEN-1:0] - b_q;
    assign div_next  = rem_ge ? {rem_diff, lo[XLEN-2:0], 1'b1}
                              : {rem_shift[XLEN-1:0], lo[XLEN-2:0], 1'b0};

    assign acc_d = op_is_div(op_q) ? div_next : mul_next;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_raw, div_fix, final_res;

    muldiv_signfix #(.XLEN(2*XLEN)) u_prod_fix (.val_i(acc_d), .neg_i(neg_q), .val_o(prod_fix));

    assign div_raw = op_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];

    muldiv_signfix #(.XLEN(XLEN)) u_div_fix (.val_i(div_raw), .neg_i(neg_q), .val_o(div_fix));

    always_comb begin
        if (op_is_div(op_q))        final_res = div_fix;
        else if (op_q[1:0] == 2'b00) final_res = prod_fix[XLEN-1:0];
        else                        final_res = prod_fix[2*XLEN-1:XLEN];
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            b_q         <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        op_q       <= funct3;
                        neg_q      <= res_neg_d;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (op_is_div(funct3)) begin
                            acc_q <= {{XLEN{1'b0}}, rs1_mag};
                            b_q   <= rs2_mag;
                        end else begin
                            acc_q <= {{XLEN{1'b0}}, rs2_mag};
                            b_q   <= rs1_mag;
                        end
                        if (div_by_zero || div_ovf) begin
                            result_q    <= special_res;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) begin
                        result_q    <= final_res;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks of muldiv_unit with a result scoreboard queue.
module tb_muldiv_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (f)
            MULDIV_MUL:    begin p = 64'(a) * 64'(b);                 return p[31:0];  end
            MULDIV_MULH:   begin p = sa * sb;                         return p[63:32]; end
            MULDIV_MULHSU: begin p = sa * longint'({32'b0, b});       return p[63:32]; end
            MULDIV_MULHU:  begin p = {32'b0, a} * {32'b0, b};         return p[63:32]; end
            MULDIV_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            MULDIV_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MULDIV_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("ready_before_issue", in_ready, 1);
        funct3   = f;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rs1      = $urandom;
        rs2      = $urandom;
        funct3   = 3'($urandom_range(0, 7));
    endtask

    // Issue, wait for out_valid (bounded), check latency, result and the handshake return.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int          n;
        logic [31:0] want;
        issue(f, a, b);
        exp_q.push_back(exp);
        @(negedge clk);
        n = 1;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_noready"}, in_ready, 0);
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(lat));
        want = exp_q.pop_front();
        check({tag, "_result"}, result, want);
        $display("op %s f=%0d a=%08h b=%08h result=%08h expected=%08h cycle=%0d",
                 tag, f, a, b, result, want, n);
        @(negedge clk);
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        logic        special, seen;
        int          n;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);

        do_op("mul",    MULDIV_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op("mulh",   MULDIV_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        do_op("mulhu",  MULDIV_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("mulhsu", MULDIV_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
        do_op("divu",   MULDIV_DIVU,   32'd100,       32'd7,         32'd14,        33);
        do_op("remu",   MULDIV_REMU,   32'd100,       32'd7,         32'd2,         33);
        do_op("div",    MULDIV_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        do_op("rem",    MULDIV_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        do_op("div_z",  MULDIV_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        do_op("remu_z", MULDIV_REMU,   32'd5,         32'd0,         32'd5,         1);
        do_op("div_ov", MULDIV_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ov", MULDIV_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

        for (int i = 0; i < 8; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (i == 5) b = 32'h0;
            special = f[2] && (b == 0 || ((f == MULDIV_DIV || f == MULDIV_REM)
                      && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
            do_op("rand", f, a, b, model(f, a, b), special ? 1 : 33);
        end

        // Backpressure: result held, no new acceptance while DONE.
        out_ready = 1'b0;
        issue(MULDIV_DIVU, 32'd1000, 32'd10);
        exp_q.push_back(32'd100);
        @(negedge clk);
        n = 1;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", 64'(n), 64'd33);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                in_valid = 1'b1;
                funct3   = MULDIV_MUL;
                rs1      = 32'd3;
                rs2      = 32'd3;
            end
            if (k == 7) in_valid = 1'b0;
            check("bp_result", result, exp_q[0]);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        $display("op backpressure result=%08h expected=%08h", result, exp_q[0]);
        @(negedge clk);
        void'(exp_q.pop_front());
        check("bp_valid_drop", out_valid, 0);
        check("bp_ready_back", in_ready, 1);
        repeat (3) begin
            @(negedge clk);
            check("bp_not_accepted", busy, 0);
        end

        // Flush in CALC at cycle 10.
        issue(MULDIV_MUL, 32'd123, 32'd456);
        repeat (10) @(negedge clk);
        check("fl_in_calc", busy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("fl_busy", busy, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_out_valid", out_valid, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("fl_no_result", seen, 0);
        $display("op flush_calc busy=%0b out_valid_seen=%0b", busy, seen);

        // Reset in CALC at cycle 20.
        issue(MULDIV_DIVU, 32'd77, 32'd5);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rs_busy", busy, 0);
        check("rs_in_ready", in_ready, 1);
        check("rs_out_valid", out_valid, 0);
        check("rs_result", result, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("rs_no_result", seen, 0);
        $display("op reset_calc busy=%0b out_valid_seen=%0b", busy, seen);

        // Flush together with in_valid in IDLE: nothing accepted.
        @(negedge clk);
        funct3   = MULDIV_DIVU;
        rs1      = 32'd9;
        rs2      = 32'd3;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check("fi_busy", busy, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("fi_no_result", seen, 0);
        $display("op flush_idle busy=%0b out_valid_seen=%0b", busy, seen);

        do_op("divu_after", MULDIV_DIVU, 32'd9, 32'd3, 32'd3, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
